// File: rtl/du_controller.sv
// Debug-unit controller: UART command protocol driving CPU run/step,
// program load and register/memory dump sequencing.
module du_controller #(
    parameter int NB_INSTRUCTION = 32,
    parameter int NB_UART_DATA = 8,
    parameter int NB_COUNTER = 32,
    parameter int HEARTBEAT_TICKS = 99_999_999,
    parameter int TIMEOUT_TICKS = 199_999_999,
    parameter logic [NB_INSTRUCTION-1:0] HALT_INSTR = 32'h1A1A1A1A,
    parameter int DRAIN_CYCLES = 3,
    parameter int STEP_GAP = 3,
    parameter int RST_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_loader_done,
    input  logic                      i_send_regs_done,
    input  logic                      i_send_dmem_done,
    input  logic [NB_INSTRUCTION-1:0] i_instr,
    input  logic [NB_UART_DATA-1:0]   i_rx_data,
    input  logic                      i_rx_done,
    output logic                      o_cpu_en,
    output logic                      o_load_start,
    output logic                      o_send_regs_start,
    output logic                      o_send_dmem_start,
    output logic                      o_rst,
    output logic [1:0]                o_imem_rsize,
    output logic                      o_rd,
    output logic                      o_wr,
    output logic                      o_tx_start,
    output logic [NB_UART_DATA-1:0]   o_wdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_MODE, S_COUNT, S_RUN, S_DRAIN, S_STEP_EXEC,
        S_STEP_GAP, S_DUMP_REGS, S_DUMP_DMEM, S_HALTED, S_RESETTING
    } state_t;

    localparam logic [NB_UART_DATA-1:0] B_SOT   = NB_UART_DATA'(8'h01);
    localparam logic [NB_UART_DATA-1:0] B_ACK   = NB_UART_DATA'(8'h05);
    localparam logic [NB_UART_DATA-1:0] B_NAK   = NB_UART_DATA'(8'h15);
    localparam logic [NB_UART_DATA-1:0] B_CAN   = NB_UART_DATA'(8'h18);
    localparam logic [NB_UART_DATA-1:0] B_CONT  = NB_UART_DATA'(8'h01);
    localparam logic [NB_UART_DATA-1:0] B_STEP  = NB_UART_DATA'(8'h02);
    localparam logic [NB_UART_DATA-1:0] B_MULTI = NB_UART_DATA'(8'h03);
    localparam logic [NB_UART_DATA-1:0] B_RSTRT = NB_UART_DATA'(8'h02);
    localparam logic [NB_UART_DATA-1:0] B_HB_MD = NB_UART_DATA'(8'h2A);
    localparam logic [NB_UART_DATA-1:0] B_HB_HL = NB_UART_DATA'(8'h30);
    localparam logic [NB_UART_DATA-1:0] ONE_B   = NB_UART_DATA'(1);

    localparam logic [NB_COUNTER-1:0] HB_LIM  = NB_COUNTER'(HEARTBEAT_TICKS);
    localparam logic [NB_COUNTER-1:0] TO_LIM  = NB_COUNTER'(TIMEOUT_TICKS);
    localparam logic [NB_COUNTER-1:0] DR_LAST = NB_COUNTER'(DRAIN_CYCLES - 1);
    localparam logic [NB_COUNTER-1:0] GP_LAST = NB_COUNTER'(STEP_GAP - 1);
    localparam logic [NB_COUNTER-1:0] RS_LAST = NB_COUNTER'(RST_CYCLES - 1);
    localparam logic [NB_COUNTER-1:0] C_ONE   = NB_COUNTER'(1);
    localparam logic [7:0]            PH_MAX  = 8'(DRAIN_CYCLES);

    state_t                  state_q, state_d;
    logic [NB_COUNTER-1:0]   hb_q, hb_d;
    logic [NB_COUNTER-1:0]   wd_q, wd_d;
    logic [NB_COUNTER-1:0]   cyc_q, cyc_d;
    logic [NB_UART_DATA-1:0] steps_q, steps_d;
    logic [7:0]              post_q, post_d;
    logic                    halt_seen_q, halt_seen_d;
    logic                    step_mode_q, step_mode_d;

    logic                    tx_proto;
    logic                    tx_evt;
    logic [NB_UART_DATA-1:0] tx_byte;
    logic                    hb_hit, wd_hit, halt_now, mode_cmd;

    assign hb_hit   = (hb_q == HB_LIM);
    assign wd_hit   = (wd_q == TO_LIM);
    assign halt_now = (i_instr == HALT_INSTR);
    assign mode_cmd = (i_rx_data == B_CONT) || (i_rx_data == B_STEP)
                   || (i_rx_data == B_MULTI) || (i_rx_data == B_CAN);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            hb_q        <= '0;
            wd_q        <= '0;
            cyc_q       <= '0;
            steps_q     <= '0;
            post_q      <= '0;
            halt_seen_q <= 1'b0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hb_q        <= hb_d;
            wd_q        <= wd_d;
            cyc_q       <= cyc_d;
            steps_q     <= steps_d;
            post_q      <= post_d;
            halt_seen_q <= halt_seen_d;
            step_mode_q <= step_mode_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        post_d      = post_q;
        halt_seen_d = halt_seen_q;
        step_mode_d = step_mode_q;
        case (state_q)
            S_IDLE: if (i_rx_done && i_rx_data == B_SOT) state_d = S_LOAD;
            S_LOAD: begin
                if (i_loader_done) state_d = S_MODE;
                else if (wd_hit)   state_d = S_IDLE;
            end
            S_MODE: if (i_rx_done) begin
                if (i_rx_data == B_CONT) begin
                    state_d     = S_RUN;
                    step_mode_d = 1'b0;
                end else if (i_rx_data == B_STEP) begin
                    state_d     = S_STEP_EXEC;
                    steps_d     = ONE_B;
                    step_mode_d = 1'b1;
                end else if (i_rx_data == B_MULTI) begin
                    state_d = S_COUNT;
                end else if (i_rx_data == B_CAN) begin
                    state_d = S_IDLE;
                end
            end
            S_COUNT: if (i_rx_done) begin
                steps_d     = (i_rx_data == '0) ? ONE_B : i_rx_data;
                step_mode_d = 1'b1;
                state_d     = S_STEP_EXEC;
            end
            S_RUN: begin
                if (halt_now) begin
                    halt_seen_d = 1'b1;
                    state_d     = S_DRAIN;
                end else if (i_rx_done && i_rx_data == B_CAN) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (cyc_q == DR_LAST) state_d = S_DUMP_REGS;
            S_STEP_EXEC: begin
                if (halt_now) halt_seen_d = 1'b1;
                if (halt_seen_q && post_q != PH_MAX) post_d = post_q + 8'd1;
                state_d = S_STEP_GAP;
            end
            S_STEP_GAP: if (cyc_q == GP_LAST) begin
                steps_d = steps_q - ONE_B;
                // steps_q <= 1 covers a zero count that would otherwise wrap
                if (steps_q <= ONE_B || post_q == PH_MAX) state_d = S_DUMP_REGS;
                else state_d = S_STEP_EXEC;
            end
            S_DUMP_REGS: begin
                if (i_send_regs_done) state_d = S_DUMP_DMEM;
                else if (wd_hit)      state_d = S_HALTED;
            end
            S_DUMP_DMEM: begin
                if (i_send_dmem_done)
                    state_d = (!step_mode_q || post_q == PH_MAX) ? S_HALTED : S_MODE;
                else if (wd_hit)
                    state_d = S_HALTED;
            end
            S_HALTED: if (i_rx_done && i_rx_data == B_RSTRT) state_d = S_RESETTING;
            S_RESETTING: if (cyc_q == RS_LAST) begin
                halt_seen_d = 1'b0;
                post_d      = '0;
                step_mode_d = 1'b0;
                steps_d     = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        hb_d = '0;
        if (state_d == state_q && !tx_proto && !hb_hit
            && (state_q == S_IDLE || state_q == S_MODE || state_q == S_HALTED))
            hb_d = hb_q + C_ONE;
        wd_d = '0;
        if (state_d == state_q && (state_q == S_LOAD
            || state_q == S_DUMP_REGS || state_q == S_DUMP_DMEM))
            wd_d = wd_q + C_ONE;
        cyc_d = '0;
        if (state_d == state_q && (state_q == S_DRAIN
            || state_q == S_STEP_GAP || state_q == S_RESETTING))
            cyc_d = cyc_q + C_ONE;
    end

    always_comb begin
        o_cpu_en          = 1'b0;
        o_load_start      = 1'b0;
        o_send_regs_start = 1'b0;
        o_send_dmem_start = 1'b0;
        o_rst             = 1'b0;
        o_imem_rsize      = 2'b00;
        o_rd              = 1'b0;
        tx_proto          = 1'b0;
        tx_evt            = 1'b0;
        tx_byte           = '0;
        case (state_q)
            S_IDLE: begin
                o_rd = i_rx_done;
                if (hb_hit) begin
                    tx_evt  = 1'b1;
                    tx_byte = B_NAK;
                end
            end
            S_LOAD: begin
                o_load_start = 1'b1;
                if (i_loader_done) begin
                    tx_proto = 1'b1;
                    tx_byte  = B_ACK;
                end else if (wd_hit) begin
                    tx_proto = 1'b1;
                    tx_byte  = B_NAK;
                end
            end
            S_MODE: begin
                o_rd = i_rx_done;
                if (i_rx_done && !mode_cmd) begin
                    tx_proto = 1'b1;
                    tx_byte  = B_NAK;
                end else if (hb_hit) begin
                    tx_evt  = 1'b1;
                    tx_byte = B_HB_MD;
                end
            end
            S_COUNT: o_rd = i_rx_done;
            S_RUN: begin
                o_cpu_en     = 1'b1;
                o_imem_rsize = 2'b11;
                o_rd         = i_rx_done && !halt_now;
            end
            S_DRAIN, S_STEP_EXEC: begin
                o_cpu_en     = 1'b1;
                o_imem_rsize = 2'b11;
            end
            S_STEP_GAP: o_imem_rsize = 2'b11;
            S_DUMP_REGS: begin
                o_send_regs_start = 1'b1;
                if (!i_send_regs_done && wd_hit) begin
                    tx_proto = 1'b1;
                    tx_byte  = B_NAK;
                end
            end
            S_DUMP_DMEM: begin
                o_send_dmem_start = 1'b1;
                if (!i_send_dmem_done && wd_hit) begin
                    tx_proto = 1'b1;
                    tx_byte  = B_NAK;
                end
            end
            S_HALTED: begin
                o_rd = i_rx_done;
                if (hb_hit) begin
                    tx_evt  = 1'b1;
                    tx_byte = B_HB_HL;
                end
            end
            S_RESETTING: o_rst = 1'b1;
            default: ;
        endcase
        o_wr       = tx_evt || tx_proto;
        o_tx_start = tx_evt || tx_proto;
        o_wdata    = tx_byte;
    end

endmodule

// File: tb/tb_du_controller.sv
// Bench for du_controller: protocol vectors, run/step/dump sequences,
// watchdog timeout and heartbeat timing, with a Tx scoreboard.
module tb_du_controller;

    localparam logic [31:0] HALT = 32'h1A1A1A1A;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_loader_done = 1'b0;
    logic        i_send_regs_done = 1'b0;
    logic        i_send_dmem_done = 1'b0;
    logic [31:0] i_instr = '0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_done = 1'b0;
    logic        o_cpu_en, o_load_start, o_send_regs_start;
    logic        o_send_dmem_start, o_rst, o_rd, o_wr, o_tx_start;
    logic [1:0]  o_imem_rsize;
    logic [7:0]  o_wdata;

    du_controller #(
        .HEARTBEAT_TICKS(9),
        .TIMEOUT_TICKS(20)
    ) dut (
        .clk(clk),
        .i_rst(i_rst),
        .i_loader_done(i_loader_done),
        .i_send_regs_done(i_send_regs_done),
        .i_send_dmem_done(i_send_dmem_done),
        .i_instr(i_instr),
        .i_rx_data(i_rx_data),
        .i_rx_done(i_rx_done),
        .o_cpu_en(o_cpu_en),
        .o_load_start(o_load_start),
        .o_send_regs_start(o_send_regs_start),
        .o_send_dmem_start(o_send_dmem_start),
        .o_rst(o_rst),
        .o_imem_rsize(o_imem_rsize),
        .o_rd(o_rd),
        .o_wr(o_wr),
        .o_tx_start(o_tx_start),
        .o_wdata(o_wdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       rd;
        logic       wr;
        logic [7:0] wdata;
    } vec_t;

    vec_t idle_tab[4];
    vec_t mode_tab[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: heartbeat bytes 0x2A/0x30 are not protocol replies
    always @(negedge clk) begin
        if (mon_en && o_wr === 1'b1) begin
            chk("tx_start", o_tx_start, 1);
            if (o_wdata != 8'h2A && o_wdata != 8'h30) begin
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected", o_wdata, 0);
                end else begin
                    chk("tx_byte", o_wdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        i_rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic all_zero(input string nm);
        @(negedge clk);
        chk(nm, {o_cpu_en, o_load_start, o_send_regs_start, o_send_dmem_start,
                 o_rst, o_imem_rsize, o_rd, o_wr, o_tx_start, o_wdata}, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clk);
        chk("rx_pop", o_rd, 1);
        nxt();
        i_rx_done = 1'b0;
        i_rx_data = '0;
    endtask

    task automatic apply_vec(input vec_t v, input string nm);
        i_rx_done = v.vld;
        i_rx_data = v.data;
        if (v.wr) exp_q.push_back(v.wdata);
        @(negedge clk);
        chk({nm, "_rd"}, o_rd, v.rd);
        chk({nm, "_wr"}, o_wr, v.wr);
        if (v.wr) chk({nm, "_wdata"}, o_wdata, v.wdata);
        nxt();
        i_rx_done = 1'b0;
        i_rx_data = '0;
    endtask

    task automatic load_quick;
        send_byte(8'h01);
        i_loader_done = 1'b1;
        exp_q.push_back(8'h05);
        @(negedge clk);
        chk("load_start", o_load_start, 1);
        nxt();
        i_loader_done = 1'b0;
    endtask

    task automatic do_dump;
        @(negedge clk);
        chk("regs_start", o_send_regs_start, 1);
        nxt();
        i_send_regs_done = 1'b1;
        @(negedge clk);
        chk("regs_start_done", o_send_regs_start, 1);
        nxt();
        i_send_regs_done = 1'b0;
        i_send_dmem_done = 1'b1;
        @(negedge clk);
        chk("dmem_start", o_send_dmem_start, 1);
        chk("regs_off", o_send_regs_start, 0);
        nxt();
        i_send_dmem_done = 1'b0;
    endtask

    task automatic rst_pulse;
        send_byte(8'h02);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("o_rst_pulse", o_rst, (k < 4) ? 1 : 0);
            nxt();
        end
    endtask

    task automatic run_to_halt;
        send_byte(8'h01);
        i_instr = HALT;
        @(negedge clk);
        chk("run_halt_cpu_en", o_cpu_en, 1);
        nxt();
        i_instr = '0;
    endtask

    initial begin
        idle_tab[0] = '{1'b1, 8'h05, 1'b1, 1'b0, 8'h00};
        idle_tab[1] = '{1'b1, 8'h18, 1'b1, 1'b0, 8'h00};
        idle_tab[2] = '{1'b0, 8'h01, 1'b0, 1'b0, 8'h00};
        idle_tab[3] = '{1'b1, 8'h02, 1'b1, 1'b0, 8'h00};
        mode_tab[0] = '{1'b1, 8'h7E, 1'b1, 1'b1, 8'h15};
        mode_tab[1] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h15};
        mode_tab[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        mode_tab[3] = '{1'b1, 8'h04, 1'b1, 1'b1, 8'h15};
        mode_tab[4] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'h15};
        mode_tab[5] = '{1'b1, 8'h15, 1'b1, 1'b1, 8'h15};

        // Heartbeat NAK on the 10th idle cycle, then every 10 cycles
        do_reset();
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (c == 0)
                chk("reset_outputs", {o_cpu_en, o_load_start, o_rst, o_wr}, 0);
            chk("hb_wr", o_wr, (c % 10 == 9) ? 1 : 0);
            if (c % 10 == 9) chk("hb_nak", o_wdata, 8'h15);
            nxt();
        end

        mon_en = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) apply_vec(idle_tab[i], "idle_vec");

        // Load with loader_done 5 cycles after SOT, then continuous run
        send_byte(8'h01);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("load_wait", o_load_start, 1);
            nxt();
        end
        i_loader_done = 1'b1;
        exp_q.push_back(8'h05);
        @(negedge clk);
        chk("ack_wr", o_wr, 1);
        nxt();
        i_loader_done = 1'b0;
        send_byte(8'h01);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("run_cpu_en", o_cpu_en, 1);
            chk("run_rsize", o_imem_rsize, 2'b11);
            nxt();
        end
        i_instr = HALT;
        @(negedge clk);
        chk("halt_cycle_cpu_en", o_cpu_en, 1);
        nxt();
        i_instr = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("drain_cpu_en", o_cpu_en, (k < 3) ? 1 : 0);
            nxt();
        end
        do_dump();
        @(negedge clk);
        chk("halted_idle", {o_cpu_en, o_send_dmem_start}, 0);
        nxt();
        send_byte(8'h01);
        rst_pulse();

        // Multi-step with count 4
        load_quick();
        send_byte(8'h03);
        send_byte(8'h04);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk("multi_cpu_en", o_cpu_en, (j % 4 == 0) ? 1 : 0);
            chk("multi_rsize", o_imem_rsize, 2'b11);
            nxt();
        end
        do_dump();
        for (int i = 0; i < 6; i++) apply_vec(mode_tab[i], "mode_vec");

        // Single steps, HALT_INSTR on the 2nd; halts after the 5th
        for (int s = 1; s <= 5; s++) begin
            send_byte(8'h02);
            i_instr = (s == 2) ? HALT : '0;
            @(negedge clk);
            chk("step_cpu_en", o_cpu_en, 1);
            nxt();
            i_instr = '0;
            for (int g = 0; g < 3; g++) begin
                @(negedge clk);
                chk("gap_cpu_en", o_cpu_en, 0);
                chk("gap_rsize", o_imem_rsize, 2'b11);
                nxt();
            end
            do_dump();
        end
        i_rx_data = 8'h7E;
        i_rx_done = 1'b1;
        @(negedge clk);
        chk("halted_pop", o_rd, 1);
        chk("halted_no_nak", o_wr, 0);
        nxt();
        i_rx_done = 1'b0;
        rst_pulse();

        // Watchdog timeout in DUMP_REGS
        load_quick();
        run_to_halt();
        repeat (3) nxt();
        exp_q.push_back(8'h15);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            chk("to_regs_start", o_send_regs_start, 1);
            chk("to_wr", o_wr, (k == 20) ? 1 : 0);
            nxt();
        end
        @(negedge clk);
        chk("to_halted", o_send_regs_start, 0);
        nxt();
        rst_pulse();

        // Reset asserted in the middle of DRAIN
        load_quick();
        run_to_halt();
        i_rst = 1'b1;
        @(negedge clk);
        chk("drain_before_rst", o_cpu_en, 1);
        nxt();
        i_rst = 1'b0;
        all_zero("mid_drain_reset");
        nxt();
        apply_vec(idle_tab[0], "post_rst_idle");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout act=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/du_controller.md
DU_CONTROLLER -- requirements
Module: du_controller

Interface
REQ-001 Parameter NB_INSTRUCTION, default 32, sets the instruction bus width; NB_UART_DATA, default 8, sets the UART byte width; NB_COUNTER, default 32, sets the heartbeat/watchdog counter width.
REQ-002 Parameter HEARTBEAT_TICKS, default 99_999_999, sets the idle heartbeat period; TIMEOUT_TICKS, default 199_999_999, sets the handshake watchdog limit.
REQ-003 Parameter HALT_INSTR, default 32'h1A1A1A1A, is the halt opcode; DRAIN_CYCLES, default 3, is the pipeline drain length; STEP_GAP, default 3, is the idle cycles after each step; RST_CYCLES, default 4, is the CPU reset pulse length.
REQ-004 clk  in  1  clock; i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_loader_done / i_send_regs_done / i_send_dmem_done  in  1 each  sub-block completion pulses.
REQ-006 i_instr  in  NB_INSTRUCTION  current fetched instruction; i_rx_data  in  NB_UART_DATA  Rx FIFO head; i_rx_done  in  1  Rx FIFO non-empty.
REQ-007 o_cpu_en, o_load_start, o_send_regs_start, o_send_dmem_start, o_rst  out  1 each  CPU/sub-block controls; o_imem_rsize  out  2  IMEM read size.
REQ-008 o_rd  out  1  Rx FIFO pop; o_wr, o_tx_start  out  1  Tx FIFO push/start; o_wdata  out  NB_UART_DATA  Tx byte.

Function
REQ-009 All outputs SHALL be combinational from state and registered counters; any output not driven by the current state SHALL be 0.
REQ-010 Bytes: SOT 0x01, ACK 0x05, NAK 0x15, CAN 0x18; commands in MODE are CONT 0x01, STEP 0x02, MULTI 0x03; the restart command in HALTED is 0x02.
REQ-011 Every rx byte consumed SHALL be qualified by i_rx_done, with o_rd=1 in that same cycle.
REQ-012 A Tx event SHALL drive o_wr=o_tx_start=1 with o_wdata for exactly one cycle. A protocol reply (ACK/NAK) SHALL override a heartbeat in the same cycle, and the heartbeat counter SHALL clear.
REQ-013 Heartbeat: in IDLE, MODE, and HALTED the counter SHALL increment each cycle. At HEARTBEAT_TICKS it SHALL send NAK, 0x2A, and 0x30 respectively, then clear. The counter SHALL clear on every state change.
REQ-014 IDLE: rx SOT -> LOAD; other bytes SHALL be popped and ignored.
REQ-015 LOAD: o_load_start=1. On i_loader_done: send ACK -> MODE. If the watchdog reaches TIMEOUT_TICKS first: send NAK -> IDLE.
REQ-016 MODE: CONT -> RUN with step_mode=0. STEP -> STEP_EXEC with steps_left=1, step_mode=1. MULTI -> COUNT. CAN -> IDLE. Any other byte: send NAK and stay.
REQ-017 COUNT: the next rx byte N SHALL load steps_left=N, with 0 treated as 1; then -> STEP_EXEC with step_mode=1.
REQ-018 RUN: o_cpu_en=1, o_imem_rsize=2'b11. i_instr==HALT_INSTR SHALL set halt_seen -> DRAIN. rx CAN -> DRAIN with halt_seen unchanged.
REQ-019 DRAIN: o_cpu_en=1, o_imem_rsize=2'b11 for exactly DRAIN_CYCLES cycles, then -> DUMP_REGS.
REQ-020 STEP_EXEC: o_cpu_en=1, o_imem_rsize=2'b11 for exactly one cycle, then -> STEP_GAP. HALT_INSTR SHALL set halt_seen. If halt_seen was already set on entry, post_halt SHALL increment, saturating at DRAIN_CYCLES.
REQ-021 STEP_GAP: o_cpu_en=0, o_imem_rsize=2'b11 for STEP_GAP cycles, then steps_left decrements. If it reaches 0 or post_halt==DRAIN_CYCLES -> DUMP_REGS; else -> STEP_EXEC.
REQ-022 DUMP_REGS: o_send_regs_start=1 until i_send_regs_done -> DUMP_DMEM. DUMP_DMEM: o_send_dmem_start=1 until i_send_dmem_done. A watchdog timeout in either state SHALL send NAK -> HALTED.
REQ-023 After a DUMP_DMEM done: if step_mode=0 or post_halt==DRAIN_CYCLES -> HALTED; else -> MODE.
REQ-024 HALTED: rx 0x02 -> RESETTING. RESETTING: o_rst=1 for RST_CYCLES cycles, clear halt_seen, post_halt, step_mode, and steps_left, then -> IDLE.
REQ-025 The watchdog SHALL count only in LOAD, DUMP_REGS, and DUMP_DMEM, and SHALL clear on entry to each of them. A done pulse in the same cycle as the timeout SHALL win.
REQ-026 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-027 i_rst SHALL, at any cycle including mid-run or mid-dump, force IDLE and clear all counters and flags; every output SHALL be 0 in the cycle following reset.

Verification
REQ-028 Heartbeat: HEARTBEAT_TICKS=9, no rx -> one-cycle NAK write 10 cycles after reset, repeating every 10 cycles.
REQ-029 Load/cont: SOT, loader_done at +5 -> ACK; CONT -> cpu_en high until HALT_INSTR, then exactly 3 more cycles; regs/dmem start in order; HALTED.
REQ-030 Multi-step: MULTI then 0x04 -> four 1-cycle cpu_en pulses spaced 4 cycles apart; dump; return to MODE.
REQ-031 Step into halt: single STEP commands with HALT_INSTR on the 2nd step -> HALTED after dump at post_halt=3.
REQ-032 Timeout: TIMEOUT_TICKS=20, withhold i_send_regs_done -> NAK at cycle 20 of DUMP_REGS -> HALTED; rx 0x02 -> o_rst high for 4 cycles -> IDLE.
REQ-033 Edge: bad byte 0x7E in MODE -> NAK, state held; i_rst asserted mid-DRAIN -> IDLE with all outputs 0.
